// File: rtl/game_end_detector_if.sv
// Match-outcome signal bundle: frame/hit/restart events in, outcome, lives and score out.
interface game_end_detector_if #(
  parameter int LIFE_W = 2
);
  logic              frame_tick;
  logic              hit_p1;
  logic              hit_p2;
  logic              restart;
  logic [1:0]        game_end;
  logic [LIFE_W-1:0] lives_p1;
  logic [LIFE_W-1:0] lives_p2;
  logic              round_reset;
  logic [7:0]        wins_p1;
  logic [7:0]        wins_p2;

  modport master (
    output frame_tick, hit_p1, hit_p2, restart,
    input  game_end, lives_p1, lives_p2, round_reset, wins_p1, wins_p2
  );

  modport slave (
    input  frame_tick, hit_p1, hit_p2, restart,
    output game_end, lives_p1, lives_p2, round_reset, wins_p1, wins_p2
  );
endinterface

// File: rtl/game_end_detector.sv
// Tank-game outcome engine: lives tracking, frame-counted draw settle window, restart handling.
// Optional macro GAME_END_SCORE_EN adds saturating per-tank match-win counters.
module game_end_detector #(
  parameter int LIVES         = 3,
  parameter int LIFE_W        = 2,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  game_end_detector_if.slave   bus
);

  localparam int CNT_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SETTLE_FRAMES - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);

  typedef enum logic [1:0] {PLAY, SETTLE, OVER} state_t;

  state_t            state;
  logic [1:0]        pend;
  logic [1:0]        pend_nx;
  logic [CNT_W-1:0]  cnt;
  logic [LIFE_W-1:0] lives1;
  logic [LIFE_W-1:0] lives2;
  logic [LIFE_W-1:0] lives1_nx;
  logic [LIFE_W-1:0] lives2_nx;
  logic [1:0]        code;
  logic [1:0]        outcome;
  logic              round_rst;
  logic              resolve;

  function automatic logic [LIFE_W-1:0] dec_sat(input logic [LIFE_W-1:0] v);
    return (v == '0) ? '0 : v - LIFE_W'(1);
  endfunction

  // Hits arriving in the resolve cycle still count toward this round.
  always_comb begin
    pend_nx   = pend | {bus.hit_p2, bus.hit_p1};
    lives1_nx = pend_nx[0] ? dec_sat(lives1) : lives1;
    lives2_nx = pend_nx[1] ? dec_sat(lives2) : lives2;
    resolve   = (state == SETTLE) && bus.frame_tick && (cnt == CNT_LAST);
    case ({lives1_nx == '0, lives2_nx == '0})
      2'b11:   outcome = 2'b11;
      2'b01:   outcome = 2'b01;
      2'b10:   outcome = 2'b10;
      default: outcome = 2'b00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= PLAY;
      pend      <= '0;
      cnt       <= '0;
      lives1    <= LIVES_INIT;
      lives2    <= LIVES_INIT;
      code      <= 2'b00;
      round_rst <= 1'b0;
    end else begin
      round_rst <= 1'b0;
      if (bus.restart) begin
        state     <= PLAY;
        pend      <= '0;
        cnt       <= '0;
        lives1    <= LIVES_INIT;
        lives2    <= LIVES_INIT;
        code      <= 2'b00;
        round_rst <= 1'b1;
      end else begin
        case (state)
          PLAY: begin
            if (bus.hit_p1 || bus.hit_p2) begin
              pend  <= {bus.hit_p2, bus.hit_p1};
              cnt   <= '0;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (resolve) begin
              lives1 <= lives1_nx;
              lives2 <= lives2_nx;
              pend   <= '0;
              cnt    <= '0;
              if (outcome != 2'b00) begin
                code  <= outcome;
                state <= OVER;
              end else begin
                state     <= PLAY;
                round_rst <= 1'b1;
              end
            end else begin
              pend <= pend_nx;
              if (bus.frame_tick) cnt <= cnt + CNT_W'(1);
            end
          end
          OVER:    ;
          default: state <= PLAY;
        endcase
      end
    end
  end

  assign bus.game_end    = code;
  assign bus.lives_p1    = lives1;
  assign bus.lives_p2    = lives2;
  assign bus.round_reset = round_rst;

`ifdef GAME_END_SCORE_EN
  logic [7:0] wins1;
  logic [7:0] wins2;

  function automatic logic [7:0] inc_sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Counts survive restart; only the hardware reset clears them.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wins1 <= '0;
      wins2 <= '0;
    end else if (!bus.restart && resolve) begin
      if (outcome == 2'b01) wins1 <= inc_sat(wins1);
      if (outcome == 2'b10) wins2 <= inc_sat(wins2);
    end
  end

  assign bus.wins_p1 = wins1;
  assign bus.wins_p2 = wins2;
`else
  assign bus.wins_p1 = '0;
  assign bus.wins_p2 = '0;
`endif

endmodule

// File: tb/tb_game_end_detector.sv
// Self-checking bench for game_end_detector: directed scenarios plus randomized events vs a rule-level model.
module tb_game_end_detector;

  localparam int LIVES         = 3;
  localparam int LIFE_W        = 2;
  localparam int SETTLE_FRAMES = 2;
  localparam int VW            = 2 + 2 * LIFE_W + 1 + 16;
`ifdef GAME_END_SCORE_EN
  localparam int EXP_W1 = 2;
`else
  localparam int EXP_W1 = 0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  game_end_detector_if #(.LIFE_W(LIFE_W)) bus ();

  game_end_detector #(
    .LIVES(LIVES), .LIFE_W(LIFE_W), .SETTLE_FRAMES(SETTLE_FRAMES)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lives, pending kills and ticks seen since the first kill of a round.
  int         m_l1, m_l2, m_ticks, m_w1, m_w2;
  bit         m_p1, m_p2, m_settle, m_over, m_rr;
  logic [1:0] m_code;

  logic [VW-1:0] obs;
  assign obs = {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset, bus.wins_p1, bus.wins_p2};

  function automatic logic [VW-1:0] exp_vec();
    return {m_code, LIFE_W'(m_l1), LIFE_W'(m_l2), m_rr, 8'(m_w1), 8'(m_w2)};
  endfunction

  task automatic model_reset();
    m_l1 = LIVES; m_l2 = LIVES; m_ticks = 0; m_w1 = 0; m_w2 = 0;
    m_p1 = 0; m_p2 = 0; m_settle = 0; m_over = 0; m_rr = 0; m_code = 2'b00;
  endtask

  task automatic model_step(input bit h1, input bit h2, input bit ft, input bit rs);
    m_rr = 0;
    if (rs) begin
      m_l1 = LIVES; m_l2 = LIVES; m_p1 = 0; m_p2 = 0; m_settle = 0;
      m_over = 0; m_code = 2'b00; m_ticks = 0; m_rr = 1;
    end else if (m_over) begin
      // outcome frozen until restart
    end else if (!m_settle) begin
      if (h1 || h2) begin
        m_p1 = h1; m_p2 = h2; m_settle = 1; m_ticks = 0;
      end
    end else begin
      m_p1 = m_p1 | h1;
      m_p2 = m_p2 | h2;
      if (ft) begin
        m_ticks++;
        if (m_ticks == SETTLE_FRAMES) begin
          if (m_p1 && m_l1 > 0) m_l1--;
          if (m_p2 && m_l2 > 0) m_l2--;
          m_p1 = 0; m_p2 = 0; m_settle = 0;
          if (m_l1 == 0 && m_l2 == 0) begin
            m_code = 2'b11; m_over = 1;
          end else if (m_l2 == 0) begin
            m_code = 2'b01; m_over = 1;
`ifdef GAME_END_SCORE_EN
            if (m_w1 < 255) m_w1++;
`endif
          end else if (m_l1 == 0) begin
            m_code = 2'b10; m_over = 1;
`ifdef GAME_END_SCORE_EN
            if (m_w2 < 255) m_w2++;
`endif
          end else begin
            m_rr = 1;
          end
        end
      end
    end
  endtask

  // stim bits: {restart, frame_tick, hit_p2, hit_p1}
  task automatic cycle(input logic [3:0] st);
    bus.hit_p1     = st[0];
    bus.hit_p2     = st[1];
    bus.frame_tick = st[2];
    bus.restart    = st[3];
    @(posedge clk);
    model_step(st[0], st[1], st[2], st[3]);
    #1;
    bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0; bus.frame_tick = 1'b0; bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle(4'b0000);
      checks++;
      if ({bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset} !== {2'b00, 2'd3, 2'd3, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i,
                 {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset}, {2'b00, 2'd3, 2'd3, 1'b0});
      end
    end
  endtask

  task automatic test_single_round();
    logic [3:0] st[$] = '{4'b0010, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100};
    foreach (st[i]) begin
      cycle(st[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL single_round[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset} !== {2'b00, 2'd3, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_round_resolve: got %h expected %h",
               {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset}, {2'b00, 2'd3, 2'd2, 1'b1});
    end
    cycle(4'b0000);
    checks++;
    if (bus.round_reset !== 1'b0) begin
      errors++; $display("FAIL single_round_pulse_width: got %b expected 0", bus.round_reset);
    end
  endtask

  task automatic test_tank1_wins();
    logic [3:0] st[$] = '{4'b1000,
                          4'b0010, 4'b0100, 4'b0100, 4'b0000,
                          4'b0010, 4'b0100, 4'b0100, 4'b0000,
                          4'b0010, 4'b0100, 4'b0100};
    logic [3:0] after[$] = '{4'b0000, 4'b0001, 4'b0100, 4'b0100, 4'b0111, 4'b0100, 4'b0000};
    foreach (st[i]) begin
      cycle(st[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL tank1_wins[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({bus.game_end, bus.lives_p2, bus.round_reset} !== {2'b01, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL tank1_wins_outcome: got %h expected %h",
               {bus.game_end, bus.lives_p2, bus.round_reset}, {2'b01, 2'd0, 1'b0});
    end
    foreach (after[i]) begin
      cycle(after[i]);
      checks++;
      if ({bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset} !== {2'b01, 2'd3, 2'd0, 1'b0}) begin
        errors++;
        $display("FAIL over_hold[%0d]: got %h expected %h", i,
                 {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset}, {2'b01, 2'd3, 2'd0, 1'b0});
      end
    end
  endtask

  task automatic test_draw();
    logic [3:0] st[$] = '{4'b1000,
                          4'b0011, 4'b0100, 4'b0100, 4'b0000,
                          4'b0011, 4'b0100, 4'b0100, 4'b0000,
                          4'b0001, 4'b0100, 4'b0010, 4'b0100};
    foreach (st[i]) begin
      cycle(st[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL draw[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({bus.game_end, bus.lives_p1, bus.lives_p2} !== {2'b11, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL draw_outcome: got %h expected %h",
               {bus.game_end, bus.lives_p1, bus.lives_p2}, {2'b11, 2'd0, 2'd0});
    end
  endtask

  task automatic test_restart_hit();
    logic [3:0] st[$] = '{4'b1000, 4'b0000, 4'b0010, 4'b0100, 4'b1001};
    foreach (st[i]) begin
      cycle(st[i]);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL restart_hit[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if ({bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset} !== {2'b00, 2'd3, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL restart_hit_state: got %h expected %h",
               {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset}, {2'b00, 2'd3, 2'd3, 1'b1});
    end
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0100);
      cycle(4'b0000);
    end
    checks++;
    if ({bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset} !== {2'b00, 2'd3, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL restart_hit_dropped: got %h expected %h",
               {bus.game_end, bus.lives_p1, bus.lives_p2, bus.round_reset}, {2'b00, 2'd3, 2'd3, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b1000);
    cycle(4'b0001);
    cycle(4'b0100);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL async_reset_immediate: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle((i % 2 == 0) ? 4'b0100 : 4'b0000);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL async_reset_after[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] st;
    cycle(4'b1000);
    for (int i = 0; i < 4000; i++) begin
      st[0] = ($urandom_range(0, 15) == 0);
      st[1] = ($urandom_range(0, 15) == 0);
      st[2] = ($urandom_range(0, 4) == 0);
      st[3] = ($urandom_range(0, 199) == 0);
      cycle(st);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random[%0d] stim=%b: got %h expected %h", i, st, obs, exp_vec());
      end
    end
  endtask

  task automatic test_score();
    logic [3:0] win1[$] = '{4'b1000,
                            4'b0010, 4'b0100, 4'b0100, 4'b0000,
                            4'b0010, 4'b0100, 4'b0100, 4'b0000,
                            4'b0010, 4'b0100, 4'b0100, 4'b0000};
    logic [3:0] drw[$]  = '{4'b1000,
                            4'b0011, 4'b0100, 4'b0100, 4'b0000,
                            4'b0011, 4'b0100, 4'b0100, 4'b0000,
                            4'b0011, 4'b0100, 4'b0100, 4'b0000};
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 13; i++) begin
        cycle((m < 2) ? win1[i] : drw[i]);
        checks++;
        if (obs !== exp_vec()) begin
          errors++; $display("FAIL score_m%0d[%0d]: got %h expected %h", m, i, obs, exp_vec());
        end
      end
    end
    checks++;
    if ({bus.wins_p1, bus.wins_p2} !== {8'(EXP_W1), 8'd0}) begin
      errors++;
      $display("FAIL score_totals: got %0d/%0d expected %0d/0", bus.wins_p1, bus.wins_p2, EXP_W1);
    end
    cycle(4'b1000);
    checks++;
    if ({bus.wins_p1, bus.wins_p2} !== {8'(EXP_W1), 8'd0}) begin
      errors++;
      $display("FAIL score_kept_on_restart: got %0d/%0d expected %0d/0", bus.wins_p1, bus.wins_p2, EXP_W1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wins_p1, bus.wins_p2} !== 16'd0) begin
      errors++; $display("FAIL score_reset: got %0d/%0d expected 0/0", bus.wins_p1, bus.wins_p2);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.hit_p1 = 1'b0; bus.hit_p2 = 1'b0; bus.frame_tick = 1'b0; bus.restart = 1'b0;
    test_reset();
    test_single_round();
    test_tank1_wins();
    test_draw();
    test_restart_hit();
    test_async_reset();
    test_random();
    test_score();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
